// File: rtl/seven_segment_scan.sv
// ---------------------------------------------------------------------------
// seven_segment_scan
//   Time-multiplexed driver for N_DIGITS common-anode seven-segment digits.
//   Each digit is lit for REFRESH_CYCLES, separated by DEAD_CYCLES with all
//   anodes off to avoid ghosting. New values are written to a shadow register
//   and copied to the active register only when the scan wraps to digit 0, so
//   a frame is never torn.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined   : zero digits above the highest nonzero digit are blanked
//                 (digit 0 is always shown), in addition to blank_in.
//     undefined : only blank_in masks digits.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   load        in   one-cycle strobe, captures digits_in/blank_in to shadow
//   digits_in   in   [4*N_DIGITS] hex nibbles, nibble i drives digit i
//   blank_in    in   [N_DIGITS] per-digit blank mask (1 = dark)
//   an          out  [N_DIGITS] anode enables, active-low, at most one low
//   seg         out  [7] segments {g,f,e,d,c,b,a}, active-low
//   frame_done  out  one-cycle pulse at each frame boundary
//
// States
//   state   | meaning
//   ST_DEAD | all anodes off for DEAD_CYCLES before lighting digit idx
//   ST_ON   | digit idx lit for REFRESH_CYCLES
// ---------------------------------------------------------------------------
module seven_segment_scan #(
  parameter int N_DIGITS       = 2,
  parameter int REFRESH_CYCLES = 20000,
  parameter int DEAD_CYCLES    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int MAX_CYC = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_TC    = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_TC  = (DEAD_CYCLES > 0) ? CNT_W'(DEAD_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wrap;

  logic [4*N_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
  logic [N_DIGITS-1:0]   shadow_blk_q, shadow_blk_d;
  logic [4*N_DIGITS-1:0] active_dig_q, active_dig_d;
  logic [N_DIGITS-1:0]   active_blk_q, active_blk_d;
  logic                  pending_q, pending_d;

  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  fd_q, fd_d;
  logic [N_DIGITS-1:0]   blank_eff;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    wrap    = 1'b0;
    case (state_q)
      ST_DEAD: begin
        if ((DEAD_CYCLES == 0) || (cnt_q == DEAD_TC)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (cnt_q == ON_TC) begin
          cnt_d   = '0;
          state_d = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_DEAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow/active pair. A commit always takes the shadow as it stood before
  // this edge, so a load landing on the wrap edge waits for the next frame.
  always_comb begin
    shadow_dig_d = load ? digits_in : shadow_dig_q;
    shadow_blk_d = load ? blank_in  : shadow_blk_q;
    pending_d    = load | (pending_q & ~wrap);
    active_dig_d = active_dig_q;
    active_blk_d = active_blk_q;
    if (wrap && pending_q) begin
      active_dig_d = shadow_dig_q;
      active_blk_d = shadow_blk_q;
    end
  end

  // Registered outputs are computed from next-state values so they change on
  // the same edge as the FSM.
  always_comb begin
    blank_eff = active_blk_d;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic seen_nz;
      seen_nz = 1'b0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
        if (active_dig_d[4*i +: 4] != 4'h0) seen_nz = 1'b1;
        if (!seen_nz) blank_eff[i] = 1'b1;
      end
    end
`endif
    an_d  = '1;
    seg_d = 7'b1111111;
    fd_d  = wrap;
    if (state_d == ST_ON) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          an_d[i] = 1'b0;
          if (!blank_eff[i]) seg_d = hex_to_seg(active_dig_d[4*i +: 4]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DEAD;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_dig_q <= '0;
      shadow_blk_q <= '0;
      active_dig_q <= '0;
      active_blk_q <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_blk_q <= shadow_blk_d;
      active_dig_q <= active_dig_d;
      active_blk_q <= active_blk_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      fd_q         <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scan
//   Scoreboard bench. The driver computes, for every cycle, the expected
//   an/seg/frame_done from a timeline model (cycle position inside the frame
//   plus the list of accepted loads) and queues it; a monitor pops and
//   compares every cycle.
// ---------------------------------------------------------------------------
module tb_seven_segment_scan;

  localparam int N = 2;
  localparam int R = 4;
  localparam int D = 1;
  localparam int P = N * (R + D);
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] digits_in = '0;
  logic [N-1:0] blank_in = '0;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         frame_done;

  always #5 clk = ~clk;

  seven_segment_scan #(
    .N_DIGITS      (N),
    .REFRESH_CYCLES(R),
    .DEAD_CYCLES   (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digits_in (digits_in),
    .blank_in  (blank_in),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  typedef struct {
    int           c;
    logic [W-1:0] val;
    logic [N-1:0] blk;
  } load_t;

  typedef struct {
    int           c;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         fd;
  } exp_t;

  load_t loads[$];
  exp_t  sb[$];
  exp_t  mon_e;

  int total = 0;
  int bad   = 0;
  bit running = 1'b1;
  int cur_c = 0;
  bit rst_prev = 1'b1;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Cycle c counts from 1 = first cycle after the last edge that saw reset.
  // Frame k occupies cycles k*P+1 .. (k+1)*P and shows the last load that
  // was sampled strictly before the wrap edge ending cycle k*P.
  function automatic exp_t model(input int c);
    exp_t         e;
    int           p, k, d, q, nib;
    logic [W-1:0] v;
    logic [N-1:0] b;
    p = (c - 1) % P;
    k = (c - 1) / P;
    d = p / (R + D);
    q = p % (R + D);
    e.c   = c;
    e.an  = '1;
    e.seg = 7'h7F;
    e.fd  = (p == 0) && (c > 1);
    if (q >= D) begin
      v = '0;
      b = '0;
      foreach (loads[j]) begin
        if (loads[j].c < k * P) begin
          v = loads[j].val;
          b = loads[j].blk;
        end
      end
      e.an[d] = 1'b0;
      nib = int'(v[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      begin
        bit seen;
        seen = 1'b0;
        for (int j = N - 1; j > d; j--) if (v[4*j +: 4] != 4'h0) seen = 1'b1;
        if (d > 0 && nib == 0 && !seen) b[d] = 1'b1;
      end
`endif
      if (!b[d]) e.seg = glyph[nib];
    end
    return e;
  endfunction

  function automatic int next_c();
    return rst_prev ? 1 : cur_c + 1;
  endfunction

  task automatic step(input bit rst, input bit ld, input logic [W-1:0] dv, input logic [N-1:0] bv);
    @(negedge clk);
    cur_c = next_c();
    sb.push_back(model(cur_c));
    reset     = rst;
    load      = ld;
    digits_in = dv;
    blank_in  = bv;
    if (rst) loads.delete();
    else if (ld) loads.push_back('{cur_c, dv, bv});
    rst_prev = rst;
  endtask

  task automatic idle_to(input int t);
    while (next_c() < t) step(1'b0, 1'b0, W'($urandom), N'($urandom));
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        total++;
        if (an !== mon_e.an || seg !== mon_e.seg || frame_done !== mon_e.fd) begin
          bad++;
          $display("FAIL outputs c=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                   mon_e.c, an, seg, frame_done, mon_e.an, mon_e.seg, mon_e.fd);
        end
        total++;
        if ($countones(~an) > 1) begin
          bad++;
          $display("FAIL onehot c=%0d got an=%b want at most one low", mon_e.c, an);
        end
      end else if (running) begin
        total++;
        bad++;
        $display("FAIL sb_empty got no expectation want one queued");
      end
    end
  end

  // Driver
  initial begin
    @(posedge clk);
    repeat (3) step(1'b1, 1'b0, '0, '0);
    idle_to(13);
    step(1'b0, 1'b1, W'(8'hA5), '0);
    idle_to(22);
    step(1'b0, 1'b1, W'(8'h12), '0);
    idle_to(25);
    step(1'b0, 1'b1, W'(8'h34), '0);
    idle_to(30);
    step(1'b0, 1'b1, W'(8'h56), '0);
    idle_to(41);
    step(1'b0, 1'b1, W'(8'h88), N'(2'b10));
    idle_to(52);
    step(1'b0, 1'b1, W'(8'h99), '0);
    idle_to(58);
    step(1'b1, 1'b1, W'(8'h77), '0);
    step(1'b1, 1'b0, '0, '0);
    idle_to(25);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), W'($urandom), N'($urandom));
      else
        step(1'b0, ($urandom_range(0, 7) == 0), W'($urandom),
             ($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
    end
    running = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised, time-multiplexed driver for N common-anode seven-segment digits. It replaces the single-digit combinational decoder with a scan engine: a per-digit refresh timer, a dead-time interval between digits to prevent ghosting, and a shadow/active register pair. New values load through a one-cycle strobe and take effect only at a frame boundary, so the display never shows a torn frame. The block sits between the keypad/display-control logic and the board pins.

## Interface
- `N_DIGITS`, 2, number of digits scanned (≥1); digit N_DIGITS-1 is most significant.
- `REFRESH_CYCLES`, 20000, clock cycles each digit is lit (≥1).
- `DEAD_CYCLES`, 4, clock cycles all anodes are off between digits (≥0; 0 means no dead phase).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `digits_in` and `blank_in` into the shadow registers.
- `digits_in`  in  4*N_DIGITS  hex nibbles; nibble i is at bits [4i+3:4i] and drives digit i.
- `blank_in`  in  N_DIGITS  per-digit blank mask; 1 forces that digit dark.
- `an`  out  N_DIGITS  anode enables, active-low, at most one low at a time.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- FSM states are DEAD and ON. Digit index `idx` counts 0..N_DIGITS-1. Phase counter `cnt` is sized $clog2(max(REFRESH_CYCLES,DEAD_CYCLES)+1).
- DEAD: `an` is all ones and `seg` is 7'b1111111. After DEAD_CYCLES cycles the FSM goes to ON with the same `idx`. If DEAD_CYCLES=0, DEAD is skipped entirely.
- ON: `an[idx]`=0 and `seg`=decode(active nibble idx), or 7'b1111111 if active blank[idx] is set. After REFRESH_CYCLES cycles, `idx` increments (wrapping N_DIGITS-1→0) and the FSM goes to DEAD.
- Decode follows the standard hex glyphs. Examples: 0→1000000, 1→1111001, 5→0010010, 8→0000000, A→0001000, F→0001110.
- Shadow/active: `load` writes the shadow registers and sets `pending`. If several loads arrive before a commit, the last one wins.
- Commit happens on the cycle `idx` wraps to 0. If `pending` is set, active←shadow and `pending` is cleared. `frame_done` pulses on this same cycle whether or not a commit occurs.
- If `load` and commit fall on the same cycle, the commit uses the old shadow. The new value lands in shadow and `pending` stays 1 for the next frame.
- `an`, `seg` and `frame_done` are registered and update on the same edge as the FSM state. The first ON cycle therefore already shows `an[idx]` low.

## Timing
- Frame period = N_DIGITS*(REFRESH_CYCLES+DEAD_CYCLES) cycles.
- Load-to-display latency: from the strobe to the next wrap to idx 0, at most one frame plus one cycle.
- Reset values: state DEAD, idx 0, cnt 0, `an` all ones, `seg` 7'b1111111, `frame_done` 0, active/shadow digits 0, blank masks 0, `pending` 0.
- The first DEAD phase after reset runs its full DEAD_CYCLES.
- Reset asserted mid-frame returns everything to the reset values on the next edge. Any uncommitted load is discarded.
- `load` during reset is ignored.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: at display time, any digit with value 0 that lies above the highest nonzero active digit is blanked. This is in addition to `blank_in`. Digit 0 is never blanked by this rule, so value 0 shows a single "0".
- `LEADING_ZERO_BLANK_EN` undefined: all digits are shown except those masked by `blank_in`.

## Test plan
- Reset: N_DIGITS=2, REFRESH=4, DEAD=1, hold `reset` 3 cycles → `an`=11, `seg`=1111111, `frame_done`=0. Release → `an`=10 on cycles 2–5, 11 on cycle 6, 01 on cycles 7–10, and `frame_done` pulses at the 10-cycle boundary.
- Load 0xA5 mid-frame → the current frame still shows 00. After the next `frame_done`, digit0 shows 0010010 and digit1 shows 0001000.
- Two loads (0x12 then 0x34) in one frame → only 0x34 is ever displayed. A `load` coincident with `frame_done` appears one frame later.
- `blank_in`=2'b10 with value 0x88 → digit1 ON phase has `seg`=1111111 and `an`=01. Digit0 shows 0000000.
- Reset asserted during digit1's ON phase with a load pending → outputs return to reset values. After release, 0x00 is displayed.
- With `LEADING_ZERO_BLANK_EN`, N_DIGITS=4, value 0x0030 → digits 3 and 2 are blank, digit1 shows 0110000 (3), digit0 shows 1000000. Value 0x0000 → only digit0 shows 0.
